// File: rtl/group_scan_bridge.sv
// group_scan_bridge
//
// Bridges a quasi-static request port (address/data/strobes held stable by a
// slow host) into single handshaked accesses on either a banked SRAM or a
// pair of registers (CR read/write, SR read-only). A transaction starts on a
// rising edge of the asynchronous scan_id trigger, which is synchronised into
// the clk domain and edge-detected.
//
// Address map:
//   addr[AW-1] = 1 : register space, addr[0] picks CR (0) or SR (1)
//   addr[AW-1] = 0 : SRAM, bank = addr[SRAM_AW +: BW], word = addr[SRAM_AW-1:0]
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   scan_id                        asynchronous transaction trigger
//   static_wen/ren/addr/wdata      quasi-static request
//   static_rdata/ready/err         result, held until the next accepted trigger
//   sram_wen/ren [NBANK]           per-bank strobes, sram_addr/sram_wdata shared
//   sram_rdata [NBANK*DW]          bank b read data in slice [b*DW +: DW]
//   sram_ready [NBANK]             per-bank ready
//   reg_wen/reg_ren, cr_wdata      register strobes and CR write data
//   cr_rdata, sr_rdata, reg_ready  register read data and ready
//
// Optional feature: define SCAN_BRIDGE_TIMEOUT_EN to abort an access that has
// not seen ready after TIMEOUT cycles (strobe dropped, error flagged, read
// data forced to zero). Without the macro an access waits indefinitely.

module group_scan_bridge #(
  parameter int          AW      = 20,
  parameter int          DW      = 32,
  parameter int          SRAM_AW = 16,
  parameter int          NBANK   = 2,
  parameter int          CR_W    = 17,
  parameter int          SR_W    = 15,
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_id,
  input  logic                  static_wen,
  input  logic                  static_ren,
  input  logic [AW-1:0]         static_addr,
  input  logic [DW-1:0]         static_wdata,
  output logic [DW-1:0]         static_rdata,
  output logic                  static_ready,
  output logic                  static_err,
  output logic [NBANK-1:0]      sram_wen,
  output logic [NBANK-1:0]      sram_ren,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DW-1:0]         sram_wdata,
  input  logic [NBANK*DW-1:0]   sram_rdata,
  input  logic [NBANK-1:0]      sram_ready,
  output logic                  reg_wen,
  output logic                  reg_ren,
  output logic [CR_W-1:0]       cr_wdata,
  input  logic [CR_W-1:0]       cr_rdata,
  input  logic [SR_W-1:0]       sr_rdata,
  input  logic                  reg_ready
);

  // BW is the true bank-select width (0 for a single bank); BV is the
  // storage width used for the bank register so it never becomes zero-width.
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 0;
  localparam int BV = (NBANK > 1) ? BW : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic sync1;
  logic sync2;
  logic sync3;
  logic prime1;
  logic prime2;
  logic low_seen;
  logic id_valid;

  logic in_is_reg;
  logic in_is_sr;
  logic [BV-1:0] in_bank;
  logic in_err;
  logic in_none;

  logic wen_q;
  logic ren_q;
  logic is_reg_q;
  logic is_sr_q;
  logic [BV-1:0] bank_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [DW-1:0] wdata_q;

  logic [NBANK-1:0] bank_sel;
  logic [DW-1:0] bank_rdata;
  logic bank_ready;
  logic sel_ready;

  logic accept;
  logic complete;
  logic expire;
  logic tmo_hit;

  // Only a handful of address bits are decoded; the rest are don't-care.
  logic unused_addr;
  assign unused_addr = ^static_addr;

  // Two-flop synchroniser plus an edge flop. prime1/prime2 mark when sync2
  // holds a genuine sample of scan_id (not just the reset value), and
  // low_seen arms edge detection only once scan_id has been observed low.
  // This keeps a trigger that is already high when reset releases from
  // being mistaken for a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      prime1   <= 1'b0;
      prime2   <= 1'b0;
      low_seen <= 1'b0;
    end else begin
      sync1  <= scan_id;
      sync2  <= sync1;
      sync3  <= sync2;
      prime1 <= 1'b1;
      prime2 <= prime1;
      if (prime2 && !sync2) begin
        low_seen <= 1'b1;
      end
    end
  end

  assign id_valid = low_seen & sync2 & ~sync3;

  // Decode of the live request, used only at the moment of acceptance.
  assign in_is_reg = static_addr[AW-1];
  assign in_is_sr  = static_addr[0];
  assign in_none   = ~static_wen & ~static_ren;
  // Writing the read-only status register is rejected like a bad request.
  assign in_err    = (static_wen & static_ren) |
                     (in_is_reg & in_is_sr & static_wen);

  generate
    if (NBANK > 1) begin : g_bank_multi
      assign in_bank = static_addr[SRAM_AW +: BV];
    end else begin : g_bank_single
      assign in_bank = 1'b0;
    end
  endgenerate

  // Per-bank select, read-data mux and ready mux for the latched bank.
  always_comb begin
    bank_sel   = '0;
    bank_rdata = '0;
    bank_ready = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_q == BV'(b)) begin
        bank_sel[b] = 1'b1;
        bank_rdata  = sram_rdata[b*DW +: DW];
        bank_ready  = sram_ready[b];
      end
    end
  end

  assign sel_ready = is_reg_q ? reg_ready : bank_ready;

`ifdef SCAN_BRIDGE_TIMEOUT_EN
  // Counts ISSUE cycles; zero on the first ISSUE cycle, so the strobe is
  // held for exactly TIMEOUT cycles before an abort.
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 16'd0;
    end else if (state != ISSUE) begin
      tmo_cnt <= 16'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == (TIMEOUT - 16'd1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Triggers arriving outside IDLE are dropped. Requests
  // that need no access (none, both strobes, SR write) skip ISSUE entirely.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (id_valid) begin
          accept = 1'b1;
          if (in_err || in_none) begin
            next_state = DONE;
          end else begin
            next_state = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          complete   = 1'b1;
          next_state = DONE;
        end else if (tmo_hit) begin
          expire     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Strobes are decoded straight from the state so they drop on the same
  // edge that leaves ISSUE, and vanish immediately on reset.
  always_comb begin
    sram_wen = '0;
    sram_ren = '0;
    reg_wen  = 1'b0;
    reg_ren  = 1'b0;
    if (state == ISSUE) begin
      if (is_reg_q) begin
        reg_wen = wen_q;
        reg_ren = ren_q;
      end else begin
        sram_wen = wen_q ? bank_sel : '0;
        sram_ren = ren_q ? bank_sel : '0;
      end
    end
  end

  // Request latch and result registers. static_ready/static_err are set on
  // the edge that enters DONE, which gives a two-cycle best case from
  // id_valid when ready is already high in the first ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      is_reg_q     <= 1'b0;
      is_sr_q      <= 1'b0;
      bank_q       <= '0;
      sram_addr_q  <= '0;
      wdata_q      <= '0;
      static_rdata <= '0;
      static_ready <= 1'b0;
      static_err   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q        <= static_wen;
        ren_q        <= static_ren;
        is_reg_q     <= in_is_reg;
        is_sr_q      <= in_is_sr;
        bank_q       <= in_bank;
        sram_addr_q  <= static_addr[SRAM_AW-1:0];
        wdata_q      <= static_wdata;
        static_ready <= in_err | in_none;
        static_err   <= in_err;
      end
      if (complete) begin
        static_ready <= 1'b1;
        if (ren_q) begin
          if (!is_reg_q) begin
            static_rdata <= bank_rdata;
          end else if (is_sr_q) begin
            static_rdata <= DW'(sr_rdata);
          end else begin
            static_rdata <= DW'(cr_rdata);
          end
        end
      end
      if (expire) begin
        static_ready <= 1'b1;
        static_err   <= 1'b1;
        if (ren_q) begin
          static_rdata <= '0;
        end
      end
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_wdata = wdata_q;
  assign cr_wdata   = wdata_q[CR_W-1:0];

endmodule

// File: tb/tb_group_scan_bridge.sv
// tb_group_scan_bridge
//
// Self-checking bench for group_scan_bridge. Each transaction is predicted
// from the address map and handshake rules (target, strobe pattern, number
// of strobe cycles, total latency from the trigger, error flag and read
// data) and compared against what the bridge does. Directed cases cover the
// documented examples, reset mid-access and a re-trigger during an access;
// the remainder is randomised. Define SCAN_BRIDGE_TIMEOUT_EN to build both
// bench and design with a 4-cycle access timeout.

module tb_group_scan_bridge;

  localparam int AW      = 20;
  localparam int DW      = 32;
  localparam int SRAM_AW = 16;
  localparam int NBANK   = 2;
  localparam int CR_W    = 17;
  localparam int SR_W    = 15;
`ifdef SCAN_BRIDGE_TIMEOUT_EN
  localparam int TMO     = 4;
  localparam bit TMO_EN  = 1'b1;
`else
  localparam int TMO     = 255;
  localparam bit TMO_EN  = 1'b0;
`endif
  localparam int MAXD    = TMO_EN ? 3 : 5;
  localparam int RETRIG_D = TMO_EN ? 3 : 8;

  logic                clk;
  logic                rst;
  logic                scan_id;
  logic                static_wen;
  logic                static_ren;
  logic [AW-1:0]       static_addr;
  logic [DW-1:0]       static_wdata;
  logic [DW-1:0]       static_rdata;
  logic                static_ready;
  logic                static_err;
  logic [NBANK-1:0]    sram_wen;
  logic [NBANK-1:0]    sram_ren;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [DW-1:0]       sram_wdata;
  logic [NBANK*DW-1:0] sram_rdata;
  logic [NBANK-1:0]    sram_ready;
  logic                reg_wen;
  logic                reg_ren;
  logic [CR_W-1:0]     cr_wdata;
  logic [CR_W-1:0]     cr_rdata;
  logic [SR_W-1:0]     sr_rdata;
  logic                reg_ready;

  int checks;
  int errors;
  logic [DW-1:0] exp_rdata;

  group_scan_bridge #(
    .AW(AW), .DW(DW), .SRAM_AW(SRAM_AW), .NBANK(NBANK),
    .CR_W(CR_W), .SR_W(SR_W), .TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk), .rst(rst), .scan_id(scan_id),
    .static_wen(static_wen), .static_ren(static_ren),
    .static_addr(static_addr), .static_wdata(static_wdata),
    .static_rdata(static_rdata), .static_ready(static_ready),
    .static_err(static_err),
    .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready),
    .reg_wen(reg_wen), .reg_ren(reg_ren), .cr_wdata(cr_wdata),
    .cr_rdata(cr_rdata), .sr_rdata(sr_rdata), .reg_ready(reg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic strobe_any();
    return (|sram_wen) | (|sram_ren) | reg_wen | reg_ren;
  endfunction

  task automatic checkZeroOutputs(input string pfx);
    checkOutput({pfx, "_strobes"}, 64'({sram_wen, sram_ren, reg_wen, reg_ren}), 64'd0);
    checkOutput({pfx, "_sram_addr"}, 64'(sram_addr), 64'd0);
    checkOutput({pfx, "_sram_wdata"}, 64'(sram_wdata), 64'd0);
    checkOutput({pfx, "_cr_wdata"}, 64'(cr_wdata), 64'd0);
    checkOutput({pfx, "_rdata"}, 64'(static_rdata), 64'd0);
    checkOutput({pfx, "_ready_err"}, 64'({static_ready, static_err}), 64'd0);
  endtask

  // One complete transaction. The responder raises the selected ready in
  // the (delay+1)-th strobe cycle; the other ready inputs are held high so
  // a bridge watching the wrong ready completes early and gets caught.
  task automatic applyStimulus(input logic wen, input logic ren,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input int delay, input bit retrig);
    int a, bank, saddr, exp_cycles, exp_edges, edges, n, extra;
    bit is_reg, is_sr, err, none, issue, timed_out, done;
    logic [NBANK-1:0] bank_bit;
    logic [2*NBANK+1:0] exp_pat;
    logic [DW-1:0] bank_data [NBANK];
    logic [CR_W-1:0] cr_val;
    logic [SR_W-1:0] sr_val;

    a         = int'(addr);
    is_reg    = (a >= (1 << (AW - 1)));
    is_sr     = (a % 2) == 1;
    bank      = (a / (1 << SRAM_AW)) % NBANK;
    saddr     = a % (1 << SRAM_AW);
    err       = (wen && ren) || (is_reg && is_sr && wen);
    none      = !wen && !ren;
    issue     = !err && !none;
    timed_out = issue && TMO_EN && (delay >= TMO);
    exp_cycles = !issue ? 0 : (timed_out ? TMO : delay + 1);
    exp_edges  = 3 + exp_cycles;
    bank_bit   = NBANK'(1 << bank);
    exp_pat    = {(!is_reg && wen) ? bank_bit : {NBANK{1'b0}},
                  (!is_reg && ren) ? bank_bit : {NBANK{1'b0}},
                  is_reg && wen, is_reg && ren};

    for (int b = 0; b < NBANK; b++) begin
      bank_data[b] = DW'($urandom);
      sram_rdata[b*DW +: DW] = bank_data[b];
    end
    cr_val   = CR_W'($urandom);
    sr_val   = SR_W'($urandom);
    cr_rdata = cr_val;
    sr_rdata = sr_val;

    if (issue && ren) begin
      if (timed_out) exp_rdata = '0;
      else if (!is_reg) exp_rdata = bank_data[bank];
      else if (is_sr) exp_rdata = DW'(sr_val);
      else exp_rdata = DW'(cr_val);
    end

    scan_id = 1'b0;
    repeat (4) tick();
    static_wen   = wen;
    static_ren   = ren;
    static_addr  = addr;
    static_wdata = wdata;
    sram_ready   = is_reg ? {NBANK{1'b1}} : ~bank_bit;
    reg_ready    = !is_reg;
    scan_id      = 1'b1;

    edges = 0;
    n     = 0;
    done  = 1'b0;
    while (!done && edges < 80) begin
      tick();
      edges++;
      if (strobe_any()) begin
        n++;
        checkOutput("strobe_pattern", 64'({sram_wen, sram_ren, reg_wen, reg_ren}), 64'(exp_pat));
        if (!is_reg) checkOutput("sram_addr", 64'(sram_addr), 64'(saddr));
        if (!is_reg && wen) checkOutput("sram_wdata", 64'(sram_wdata), 64'(wdata));
        if (is_reg && wen) checkOutput("cr_wdata", 64'(cr_wdata), 64'(wdata % (1 << CR_W)));
        if (n == delay + 1) begin
          sram_ready = {NBANK{1'b1}};
          reg_ready  = 1'b1;
        end
        if (retrig && n == 1) scan_id = 1'b0;
        if (retrig && n == 2) scan_id = 1'b1;
      end
      if (edges >= 3 && static_ready) done = 1'b1;
    end
    sram_ready = '0;
    reg_ready  = 1'b0;

    checkOutput("txn_completed", 64'(done), 64'd1);
    checkOutput("latency_edges", 64'(edges), 64'(exp_edges));
    checkOutput("strobe_cycles", 64'(n), 64'(exp_cycles));
    checkOutput("static_err", 64'(static_err), 64'(err || timed_out));
    checkOutput("static_rdata", 64'(static_rdata), 64'(exp_rdata));

    extra = 0;
    repeat (6) begin
      tick();
      if (strobe_any()) extra++;
    end
    checkOutput("post_no_strobe", 64'(extra), 64'd0);
    checkOutput("post_ready_held", 64'({static_ready, static_err}), 64'({1'b1, err || timed_out}));
  endtask

  initial begin
    int seen, cnt;
    logic [AW-1:0] ra;
    checks       = 0;
    errors       = 0;
    exp_rdata    = '0;
    rst          = 1'b1;
    scan_id      = 1'b0;
    static_wen   = 1'b0;
    static_ren   = 1'b0;
    static_addr  = '0;
    static_wdata = '0;
    sram_rdata   = '0;
    sram_ready   = '0;
    cr_rdata     = '0;
    sr_rdata     = '0;
    reg_ready    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkZeroOutputs("reset");
    rst = 1'b0;
    repeat (3) tick();

    $display("[TB] directed: SRAM write, CR read, SR write");
    applyStimulus(1'b1, 1'b0, 20'h1_0040, 32'hA5A5_5A5A, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 20'h8_0000, 32'h0, 3, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h8_0001, 32'h1234_5678, 0, 1'b0);

    $display("[TB] directed: both strobes, no strobe, SR read, CR write");
    applyStimulus(1'b1, 1'b1, 20'h0_0100, 32'h1, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 20'h0_0100, 32'h2, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 20'h8_0001, 32'h0, 2, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h8_0000, 32'hFFFF_FFFF, 1, 1'b0);

    $display("[TB] directed: re-trigger during access");
    applyStimulus(1'b0, 1'b1, 20'h1_2345, 32'h0, RETRIG_D, 1'b1);

`ifdef SCAN_BRIDGE_TIMEOUT_EN
    $display("[TB] directed: access timeout");
    applyStimulus(1'b0, 1'b1, 20'h0_0200, 32'h0, 50, 1'b0);
`endif

    $display("[TB] directed: reset during access with trigger held");
    scan_id = 1'b0;
    repeat (4) tick();
    static_wen  = 1'b0;
    static_ren  = 1'b1;
    static_addr = 20'h0_0010;
    sram_ready  = '0;
    reg_ready   = 1'b0;
    scan_id     = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (strobe_any()) seen = 1;
    end
    checkOutput("rst_test_issue", 64'(seen), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkZeroOutputs("rst_mid");
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      tick();
      if (strobe_any() || static_ready) cnt++;
    end
    checkOutput("rst_no_retrigger", 64'(cnt), 64'd0);
    applyStimulus(1'b0, 1'b1, 20'h0_0010, 32'h0, 1, 1'b0);

    $display("[TB] random transactions");
    for (int t = 0; t < 24; t++) begin
      ra = AW'($urandom) & 20'h7_FFFF;
      if ($urandom_range(0, 1) == 1) ra = ra | 20'h8_0000;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ra, DW'($urandom), int'($urandom_range(0, MAXD)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
